// File: rtl/input_repeater.sv
// Direction-level to game-command converter: DAS/ARR for left/right, soft-drop repeat, rotate.
// Optional `ROTATE_REPEAT_EN: rotate also auto-repeats on the DAS/ARR schedule.
module input_repeater #(
  parameter int DAS_DELAY   = 16_000_000,
  parameter int ARR_PERIOD  = 5_000_000,
  parameter int DROP_PERIOD = 4_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd
);

  localparam int MAXP0 = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int MAXP  = (MAXP0 > DROP_PERIOD) ? MAXP0 : DROP_PERIOD;
  localparam int CW    = $clog2(MAXP);

  localparam logic [CW-1:0] DAS_LAST  = CW'(DAS_DELAY - 1);
  localparam logic [CW-1:0] ARR_LAST  = CW'(ARR_PERIOD - 1);
  localparam logic [CW-1:0] DROP_LAST = CW'(DROP_PERIOD - 1);

  typedef enum logic [1:0] {
    H_IDLE,
    H_DELAY,
    H_REPEAT
  } h_state_t;

  h_state_t      h_state, h_next;
  logic          dir, dir_next;
  logic [CW-1:0] hcnt, hcnt_next;
  logic          h_raise;

  logic          eff, eff_dir;
  logic          raise_l, raise_r, raise_d, raise_u;

  // dir: 0 = left, 1 = right; both pressed cancels out
  assign eff     = left ^ right;
  assign eff_dir = right;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_state <= H_IDLE;
      dir     <= 1'b0;
      hcnt    <= '0;
    end else begin
      h_state <= h_next;
      dir     <= dir_next;
      hcnt    <= hcnt_next;
    end
  end

  always_comb begin
    h_next    = h_state;
    dir_next  = dir;
    hcnt_next = hcnt;
    h_raise   = 1'b0;
    unique case (h_state)
      H_IDLE: begin
        if (eff) begin
          h_raise   = 1'b1;
          dir_next  = eff_dir;
          hcnt_next = '0;
          h_next    = H_DELAY;
        end
      end
      H_DELAY, H_REPEAT: begin
        if (!eff) begin
          hcnt_next = '0;
          h_next    = H_IDLE;
        end else if (eff_dir != dir) begin
          h_raise   = 1'b1;
          dir_next  = eff_dir;
          hcnt_next = '0;
          h_next    = H_DELAY;
        end else if (hcnt == ((h_state == H_DELAY) ? DAS_LAST : ARR_LAST)) begin
          h_raise   = 1'b1;
          hcnt_next = '0;
          h_next    = H_REPEAT;
        end else begin
          hcnt_next = hcnt + CW'(1);
        end
      end
      default: h_next = H_IDLE;
    endcase
  end

  assign raise_l = h_raise & ~dir_next;
  assign raise_r = h_raise & dir_next;

  logic          down_q;
  logic [CW-1:0] dcnt;
  logic          down_rise, drop_tick;

  assign down_rise = down & ~down_q;
  assign drop_tick = down & down_q & (dcnt == DROP_LAST);
  assign raise_d   = down_rise | drop_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      down_q <= 1'b0;
      dcnt   <= '0;
    end else begin
      down_q <= down;
      if (!down || down_rise || drop_tick)
        dcnt <= '0;
      else
        dcnt <= dcnt + CW'(1);
    end
  end

  logic up_q, up_rise;

  assign up_rise = up & ~up_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) up_q <= 1'b0;
    else          up_q <= up;
  end

`ifdef ROTATE_REPEAT_EN
  logic          r_rep;
  logic [CW-1:0] rcnt;
  logic          rot_tick;

  assign rot_tick = up & up_q & (rcnt == (r_rep ? ARR_LAST : DAS_LAST));
  assign raise_u  = up_rise | rot_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rep <= 1'b0;
      rcnt  <= '0;
    end else if (!up || up_rise) begin
      r_rep <= 1'b0;
      rcnt  <= '0;
    end else if (rot_tick) begin
      r_rep <= 1'b1;
      rcnt  <= '0;
    end else begin
      rcnt  <= rcnt + CW'(1);
    end
  end
`else
  assign raise_u = up_rise;
`endif

  logic [3:0] pend, clr, avail, raise;
  logic       accept;
  logic [1:0] pick;

  assign raise  = {raise_u, raise_d, raise_r, raise_l};
  assign accept = cmd_valid & cmd_ready;
  assign clr    = accept ? (4'b0001 << cmd) : 4'b0000;
  // a raise coinciding with its own accept wins, keeping the flag set
  assign avail  = pend & ~clr;

  always_comb begin
    pick = 2'd0;
    if (avail[3])      pick = 2'd3;
    else if (avail[0]) pick = 2'd0;
    else if (avail[1]) pick = 2'd1;
    else if (avail[2]) pick = 2'd2;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend      <= 4'b0000;
      cmd_valid <= 1'b0;
      cmd       <= 2'd0;
    end else begin
      pend <= avail | raise;
      if (!cmd_valid || accept) begin
        cmd_valid <= |avail;
        if (|avail) cmd <= pick;
      end
    end
  end

endmodule

// File: tb/tb_input_repeater.sv
// Directed bench for input_repeater with DAS=8, ARR=3, DROP=4.
// Expected cmd_valid/cmd patterns are hand-derived per cycle.
module tb_input_repeater;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       up, down, left, right;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd;

  int checks = 0;
  int errors = 0;

  input_repeater #(
    .DAS_DELAY  (8),
    .ARR_PERIOD (3),
    .DROP_PERIOD(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd      (cmd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit ev,
                         input logic [1:0] ec);
    chk({tag, "_valid"}, {7'd0, cmd_valid}, {7'd0, ev});
    if (ev) chk({tag, "_cmd"}, {6'd0, cmd}, {6'd0, ec});
  endtask

  initial begin
    bit ev;
    reset_n = 1'b0;
    up = 0; down = 0; left = 0; right = 0;
    cmd_ready = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 2'd0);
    chk("reset_cmd", {6'd0, cmd}, 8'd0);
    reset_n = 1'b1;
    tick();
    chk_out("idle", 1'b0, 2'd0);

    // left held 20 edges: raises at 0,8,11,14,17 -> valid one edge later
    left = 1;
    for (int i = 0; i < 25; i++) begin
      tick();
      ev = (i == 1 || i == 9 || i == 12 || i == 15 || i == 18);
      chk_out("left_hold", ev, 2'd0);
      if (i == 19) left = 0;
    end

    // both high cancels; dropping right is a fresh left press
    left = 1; right = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("both", 1'b0, 2'd0);
    end
    right = 0;
    for (int i = 0; i <= 10; i++) begin
      tick();
      ev = (i == 1 || i == 9);
      chk_out("left_after_both", ev, 2'd0);
    end
    left = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("left_rel", 1'b0, 2'd0);
    end

    // up and left together: rotate then left back-to-back
    up = 1; left = 1;
    tick(); chk_out("ul0", 1'b0, 2'd0);
    tick(); chk_out("ul1", 1'b1, 2'd3);
    tick(); chk_out("ul2", 1'b1, 2'd0);
    tick(); chk_out("ul3", 1'b0, 2'd0);
    up = 0; left = 0;
    tick(); tick();

    // down held with stalled consumer; repeats merge into one
    cmd_ready = 0; down = 1;
    tick(); chk_out("drop0", 1'b0, 2'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_out("drop_stall", 1'b1, 2'd2);
    end
    down = 0; cmd_ready = 1;
    for (int i = 11; i <= 14; i++) begin
      tick();
      chk_out("drop_drain", 1'b0, 2'd0);
    end

    // right and drop together: right has priority
    cmd_ready = 0; down = 1; right = 1;
    tick(); chk_out("pr0", 1'b0, 2'd0);
    tick(); chk_out("pr1", 1'b1, 2'd1);
    cmd_ready = 1;
    tick(); chk_out("pr2", 1'b1, 2'd2);
    tick(); chk_out("pr3", 1'b0, 2'd0);
    down = 0; right = 0;
    tick(); tick();

    // up held 12 edges
    up = 1;
    for (int i = 0; i < 14; i++) begin
      tick();
`ifdef ROTATE_REPEAT_EN
      ev = (i == 1 || i == 9 || i == 12);
`else
      ev = (i == 1);
`endif
      chk_out("up_hold", ev, 2'd3);
      if (i == 11) up = 0;
    end

    // asynchronous reset while a command is pending
    cmd_ready = 0; right = 1;
    tick();
    tick(); chk_out("pre_rst", 1'b1, 2'd1);
    #2 reset_n = 0; right = 0;
    #1 chk("async_rst_valid", {7'd0, cmd_valid}, 8'd0);
    chk("async_rst_cmd", {6'd0, cmd}, 8'd0);
    tick();
    reset_n = 1; cmd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("post_rst", 1'b0, 2'd0);
    end

    // up held across reset release counts as a press
    reset_n = 0; up = 1;
    tick(); chk_out("rst_up_hold", 1'b0, 2'd0);
    reset_n = 1;
    tick(); chk_out("rel0", 1'b0, 2'd0);
    tick(); chk_out("rel1", 1'b1, 2'd3);
    up = 0;
    tick(); chk_out("rel2", 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_repeater.md
# input_repeater

Converts the debounced direction levels from the button stage into a stream of discrete game commands for the Tetris game-logic FSM. Left/right get delayed auto-shift (DAS) followed by auto-repeat (ARR). Down gets periodic soft-drop repeat. Up is rotate. Commands are queued as sticky pending flags and issued one at a time over a valid/ready handshake.

## Interface
- `DAS_DELAY`, default 16_000_000: cycles from the initial horizontal move to the first auto-repeat (min 2).
- `ARR_PERIOD`, default 5_000_000: cycles between horizontal auto-repeats (min 2).
- `DROP_PERIOD`, default 4_000_000: cycles between soft-drop repeats (min 2).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `up`  in  1  debounced rotate level, synchronous to `clk`.
- `down`  in  1  debounced soft-drop level.
- `left`  in  1  debounced left level.
- `right`  in  1  debounced right level.
- `cmd_valid`  out  1  command available.
- `cmd`  out  2  command code: 0 = left, 1 = right, 2 = drop, 3 = rotate.
- `cmd_ready`  in  1  consumer accepts the command when `cmd_valid && cmd_ready` at a rising edge.

## Operation
**Horizontal FSM.** States are `H_IDLE`, `H_DELAY`, `H_REPEAT`. It holds a direction register `dir` and a counter sized by `$clog2` of the largest parameter.
- An effective direction exists only when exactly one of `left`/`right` is high. Both high counts as none.
- `H_IDLE` with an effective direction: raise the pending flag for that direction, latch `dir`, clear the counter, go to `H_DELAY`.
- `H_DELAY`: when the counter reaches `DAS_DELAY-1`, raise pending, clear the counter, go to `H_REPEAT`.
- `H_REPEAT`: when the counter reaches `ARR_PERIOD-1`, raise pending and clear the counter.
- In `H_DELAY` or `H_REPEAT`, if there is no effective direction, go to `H_IDLE`.
- In `H_DELAY` or `H_REPEAT`, if the effective direction differs from `dir`, treat it as a fresh press: raise pending for the new direction, latch it, clear the counter, go to `H_DELAY`.

**Drop.** On a rising edge of `down`, raise pending-drop. While `down` stays held, a counter raises pending-drop every `DROP_PERIOD` cycles. Releasing `down` clears the counter.

**Rotate.** A rising edge of `up` raises pending-rotate.

**Pending flags and issue.** There is one sticky flag per command.
- Raising a flag that is already set merges into it; there is no second entry.
- A flag is cleared in the cycle its command is accepted.
- If a raise and an accept of the same flag coincide, the flag stays set.
- Issue priority: rotate > left > right > drop.

**Output register.**
- When `cmd_valid` is low and any flag is set, load `cmd` with the highest-priority code and assert `cmd_valid`.
- While `cmd_valid && !cmd_ready`, `cmd` and `cmd_valid` hold stable. Newly raised flags wait.
- On accept, the output register may reload in the same edge, so back-to-back commands are possible.

**Reset mid-operation.** Asserting `reset_n` low immediately clears all state and outputs, including any command not yet accepted.

## Timing
- Reset values: `cmd_valid` = 0, `cmd` = 0. All FSMs idle, counters and pending flags 0, previous-input registers 0.
- Latency: input first sampled high at edge E0 sets pending at E0. `cmd_valid` is high after E1 when the output is free.
- First horizontal repeat is raised at E0 + `DAS_DELAY`. Later repeats every `ARR_PERIOD` edges.
- Drop repeats are raised at E0 + k·`DROP_PERIOD`.
- A level held across reset deassertion counts as a press at the first edge after release.
- Peak throughput is one command per cycle with `cmd_ready` tied high.

## Configuration
- `ROTATE_REPEAT_EN` defined: rotate also auto-repeats while `up` is held, using the DAS_DELAY/ARR_PERIOD schedule with its own counter. The horizontal counter is not shared.
- `ROTATE_REPEAT_EN` undefined: rotate fires on the rising edge only, and the rotate counter is not instantiated.

## Test plan
Parameters: DAS_DELAY=8, ARR_PERIOD=3, DROP_PERIOD=4; `cmd_ready` = 1 unless stated.
- Hold `left` for 20 cycles → left commands raised at E0, E0+8, E0+11, E0+14, E0+17; none after release.
- `left` and `right` both high → no horizontal commands. Drop `right` → a left command and a fresh DAS schedule.
- `up` and `left` pressed in the same cycle → `cmd` = 3, then `cmd` = 0 on consecutive cycles.
- `cmd_ready` = 0 for 10 cycles while `down` is held → `cmd` = 2 stays stable with `cmd_valid` high. After release exactly one drop is issued per accept, with merged repeats counted once.
- Hold `up` for 12 cycles → one rotate without `ROTATE_REPEAT_EN`; rotates at E0 and E0+8, E0+11 with it defined.
- Pull `reset_n` low while `cmd_valid` = 1 → `cmd_valid` = 0 with no clock edge. No stale command after release.
